// File: rtl/crc_framer_if.sv
// Serial framer handshake bundle: payload bits in, framed payload + CRC24B bits out.
interface crc_framer_if;
  logic sof_in;
  logic blk_sel_in;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic block_size;
  logic crc_start;
  logic crc_data;
  logic crc_end;
  logic out_valid;
  logic busy;
  logic sof_err;

  modport master (
    output sof_in, blk_sel_in, in_valid, in_data,
    input  in_ready, block_size, crc_start, crc_data, crc_end, out_valid, busy, sof_err
  );

  modport slave (
    input  sof_in, blk_sel_in, in_valid, in_data,
    output in_ready, block_size, crc_start, crc_data, crc_end, out_valid, busy, sof_err
  );
endinterface

// File: rtl/crc_framer.sv
// Bit-serial CRC24B framer: passes K-24 payload bits through one register stage,
// then appends the 24-bit CRC MSB first and idles one gap cycle.
module crc_framer (
  input  logic         clk,
  input  logic         reset,
  crc_framer_if.slave  bus
);
  localparam logic [23:0] POLY  = 24'h800063;
  localparam logic [12:0] LEN_S = 13'd1032;
  localparam logic [12:0] LEN_L = 13'd6120;

  typedef enum logic [1:0] {IDLE, PAYLOAD, APPEND, GAP} state_t;

  state_t      state, state_nx;
  logic [12:0] cnt, cnt_nx;
  logic [23:0] crc, crc_nx;
  logic        bsel, bsel_nx;
  logic        ov, od, os, oe, se;
  logic        ov_nx, od_nx, os_nx, oe_nx, se_nx;
  logic        accept;
  logic [12:0] plen;

  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic d);
    crc_step = {c[22:0], 1'b0} ^ ((c[23] ^ d) ? POLY : 24'h0);
  endfunction

  assign bus.in_ready   = (state == IDLE) || (state == PAYLOAD);
  assign bus.busy       = (state != IDLE);
  assign bus.block_size = bsel;
  assign bus.out_valid  = ov;
  assign bus.crc_data   = od;
  assign bus.crc_start  = os;
  assign bus.crc_end    = oe;
  assign bus.sof_err    = se;

  assign accept = bus.in_valid && bus.in_ready;
  assign plen   = bsel ? LEN_L : LEN_S;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      crc  <= '0;
      bsel <= 1'b0;
      ov   <= 1'b0;
      od   <= 1'b0;
      os   <= 1'b0;
      oe   <= 1'b0;
      se   <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      crc  <= crc_nx;
      bsel <= bsel_nx;
      ov   <= ov_nx;
      od   <= od_nx;
      os   <= os_nx;
      oe   <= oe_nx;
      se   <= se_nx;
    end
  end

  // Output flags are registered, so every output lags the state that produced it by one cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    crc_nx   = crc;
    bsel_nx  = bsel;
    ov_nx    = 1'b0;
    od_nx    = 1'b0;
    os_nx    = 1'b0;
    oe_nx    = 1'b0;
    se_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && bus.sof_in) begin
          bsel_nx  = bus.blk_sel_in;
          crc_nx   = crc_step(24'h0, bus.in_data);
          cnt_nx   = 13'd1;
          ov_nx    = 1'b1;
          od_nx    = bus.in_data;
          os_nx    = 1'b1;
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          crc_nx = crc_step(crc, bus.in_data);
          cnt_nx = cnt + 13'd1;
          ov_nx  = 1'b1;
          od_nx  = bus.in_data;
          se_nx  = bus.sof_in;
          if (cnt == plen - 13'd1) begin
            cnt_nx   = '0;
            state_nx = APPEND;
          end
        end
      end
      APPEND: begin
        ov_nx  = 1'b1;
        od_nx  = crc[23];
        crc_nx = {crc[22:0], 1'b0};
        cnt_nx = cnt + 13'd1;
        if (cnt == 13'd23) begin
          oe_nx    = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_crc_framer.sv
// Directed table-driven bench for crc_framer: framing, latency, CRC field, gaps, sof errors, reset abort.
module tb_crc_framer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crc_framer_if bus();
  crc_framer dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        bs;
    int          pat;
    int          gap;
    int          sofp;
    logic        has_exp;
    logic [23:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // monitor state
  logic obits[$];
  int   n_start, n_end, n_serr, bs_bad, viol;
  logic exp_bs = 1'b0;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      obits.push_back(bus.crc_data);
      if (bus.crc_start) n_start++;
      if (bus.crc_end) n_end++;
      if (bus.block_size !== exp_bs) bs_bad++;
    end else if (bus.crc_start || bus.crc_end || bus.crc_data) begin
      viol++;
    end
    if (bus.sof_err) n_serr++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic pbit(input int pat, input int i, input int len);
    case (pat)
      1:       return (i == len);
      2:       return (i == len - 1);
      3:       return i[0];
      4:       return ((i % 7) == 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [23:0] crc_ref(input int pat, input int len);
    logic [23:0] c;
    logic        fb;
    c = '0;
    for (int i = 1; i <= len; i++) begin
      fb = c[23] ^ pbit(pat, i, len);
      c  = {c[22:0], 1'b0} ^ (fb ? 24'h800063 : 24'h0);
    end
    return c;
  endfunction

  task automatic clear_mon();
    obits.delete();
    n_start = 0; n_end = 0; n_serr = 0; bs_bad = 0; viol = 0;
  endtask

  // Called just after a negedge where in_ready=1; returns just after the first IDLE negedge.
  task automatic run_block(input vec_t v, input string tag);
    int          len, i, lat_err, nlow, app_bad, pay_bad;
    logic        acc, b;
    logic [23:0] crc_o, ref_c;
    len = v.bs ? 6120 : 1032;
    exp_bs = v.bs;
    clear_mon();
    lat_err = 0;
    i = 1;
    while (i <= len) begin
      b = pbit(v.pat, i, len);
      if (v.gap > 0 && i > 1 && $urandom_range(0, v.gap - 1) == 0) begin
        acc = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'($urandom);
        bus.sof_in   = 1'b0;
      end else begin
        acc = 1'b1;
        if (!bus.in_ready) lat_err++;
        bus.in_valid   = 1'b1;
        bus.in_data    = b;
        bus.sof_in     = (i == 1) || (i == v.sofp);
        bus.blk_sel_in = (i == 1) ? v.bs : ~v.bs;
      end
      @(negedge clk);
      if (acc) begin
        if (!(bus.out_valid && bus.crc_data == b && bus.crc_start == (i == 1))) lat_err++;
        i++;
      end else if (bus.out_valid) begin
        lat_err++;
      end
    end
    bus.in_valid = 1'b0;
    bus.sof_in   = 1'b0;
    nlow = 0;
    app_bad = 0;
    while (!bus.in_ready && nlow < 100) begin
      if (!bus.out_valid) app_bad++;
      nlow++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat_err, 0);
    chk({tag, " ready_low_cycles"}, nlow, 25);
    chk({tag, " append_contig"}, app_bad, 0);
    chk({tag, " gap_bubble"}, int'(bus.out_valid), 0);
    chk({tag, " out_len"}, obits.size(), len + 24);
    chk({tag, " starts"}, n_start, 1);
    chk({tag, " ends"}, n_end, 1);
    chk({tag, " sof_err"}, n_serr, (v.sofp > 0) ? 1 : 0);
    chk({tag, " block_size"}, bs_bad, 0);
    chk({tag, " idle_zero"}, viol, 0);
    if (obits.size() >= len + 24) begin
      pay_bad = 0;
      for (int k = 0; k < len; k++) if (obits[k] !== pbit(v.pat, k + 1, len)) pay_bad++;
      crc_o = '0;
      for (int k = 0; k < 24; k++) crc_o = {crc_o[22:0], obits[len + k]};
      ref_c = crc_ref(v.pat, len);
      chk({tag, " payload"}, pay_bad, 0);
      chk({tag, " crc_model"}, int'(crc_o), int'(ref_c));
      if (v.has_exp) chk({tag, " crc_const"}, int'(crc_o), int'(v.exp));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, int'(bus.in_ready), 1);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " block_size"}, int'(bus.block_size), 0);
    chk({tag, " flags"}, int'({bus.crc_start, bus.crc_data, bus.crc_end, bus.sof_err}), 0);
  endtask

  vec_t vecs[7];
  vec_t tail;
  int   idle_bad;

  initial begin
    // bs, pattern, gap 1-in-N, sof position, has constant, constant CRC
    vecs[0] = '{1'b0, 0, 0, 0,   1'b1, 24'h000000};  // all-zero short block
    vecs[1] = '{1'b1, 1, 0, 0,   1'b1, 24'h800063};  // long block, last bit one
    vecs[2] = '{1'b1, 1, 3, 0,   1'b1, 24'h800063};  // same with input gaps
    vecs[3] = '{1'b0, 0, 0, 500, 1'b1, 24'h000000};  // stray sof on bit 500
    vecs[4] = '{1'b0, 2, 0, 0,   1'b1, 24'h8000A5};  // one in second-to-last bit
    vecs[5] = '{1'b0, 3, 0, 0,   1'b0, 24'h0};       // alternating bits
    vecs[6] = '{1'b1, 4, 4, 0,   1'b0, 24'h0};       // sparse pattern with gaps
    tail    = '{1'b0, 4, 0, 0,   1'b0, 24'h0};

    bus.sof_in = 1'b0; bus.blk_sel_in = 1'b0; bus.in_valid = 1'b0; bus.in_data = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // non-sof bits in IDLE are dropped
    idle_bad = 0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 1'b1; bus.sof_in = 1'b0; bus.blk_sel_in = 1'b1;
      @(negedge clk);
      if (bus.out_valid || bus.busy || bus.block_size) idle_bad++;
    end
    chk("idle_discard", idle_bad, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // records run back to back: each starts on the first IDLE cycle after the previous
    for (int r = 0; r < 7; r++) run_block(vecs[r], $sformatf("vec%0d", r));

    // abort a long block at payload bit 300 with a reset pulse
    exp_bs = 1'b1;
    clear_mon();
    for (int i = 1; i <= 300; i++) begin
      bus.in_valid = 1'b1; bus.in_data = pbit(3, i, 6120);
      bus.sof_in = (i == 1); bus.blk_sel_in = 1'b1;
      @(negedge clk);
    end
    chk("abort busy_before", int'(bus.busy), 1);
    bus.in_valid = 1'b0; bus.sof_in = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort no_end", n_end, 0);
    run_block(tail, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
